// File: rtl/sync_up_counter_mod.sv
// Modulo-N up counter with enable, synchronous clear/load, cascade carry (tc),
// a registered wrap pulse and a sticky overflow flag.
module sync_up_counter_mod #(
    parameter int WIDTH    = 3,
    parameter int MODULO   = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    generate
        if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
            $error("sync_up_counter_mod: MODULO must lie in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

    logic at_max;

    assign at_max = (q == MAX_VAL);
    assign tc     = en & ~clr & ~load & at_max;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else if (clr) begin
            q    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else if (load) begin
            // Out-of-range load values clamp to the top of the sequence.
            q    <= (load_val > MAX_VAL) ? MAX_VAL : load_val;
            wrap <= 1'b0;
        end else if (en) begin
            if (at_max) begin
                ovf <= 1'b1;
                if (SATURATE) begin
                    wrap <= 1'b0;
                end else begin
                    q    <= '0;
                    wrap <= 1'b1;
                end
            end else begin
                q    <= q + WIDTH'(1);
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_up_counter_mod.sv
// Bench for sync_up_counter_mod: three instances (mod 8 wrap, mod 5 wrap,
// mod 8 saturate) share one stimulus stream and one arithmetic reference model.
`timescale 1ns/1ps
module tb_sync_up_counter_mod;

    localparam int W = 3;
    localparam int N = 3;
    localparam int MODS [N] = '{8, 5, 8};
    localparam bit SATS [N] = '{1'b0, 1'b0, 1'b1};

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         en   = 1'b0;
    logic         clr  = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] lv   = '0;

    logic [W-1:0] dq    [N];
    logic         dtc   [N];
    logic         dwrap [N];
    logic         dovf  [N];

    int m_q    [N];
    bit m_wrap [N];
    bit m_ovf  [N];

    logic [W-1:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    sync_up_counter_mod #(.WIDTH(3), .MODULO(8), .SATURATE(1'b0)) u_m8 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(lv),
        .q(dq[0]), .tc(dtc[0]), .wrap(dwrap[0]), .ovf(dovf[0]));

    sync_up_counter_mod #(.WIDTH(3), .MODULO(5), .SATURATE(1'b0)) u_m5 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(lv),
        .q(dq[1]), .tc(dtc[1]), .wrap(dwrap[1]), .ovf(dovf[1]));

    sync_up_counter_mod #(.WIDTH(3), .MODULO(8), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(lv),
        .q(dq[2]), .tc(dtc[2]), .wrap(dwrap[2]), .ovf(dovf[2]));

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic on the count value.
    function automatic bit model_tc(int i);
        return rst && en && !clr && !load && (m_q[i] == MODS[i] - 1);
    endfunction

    task automatic model_edge();
        int nxt;
        for (int i = 0; i < N; i++) begin
            if (!rst) begin
                m_q[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
            end else if (clr) begin
                m_q[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
            end else if (load) begin
                m_q[i]    = (int'(lv) > MODS[i] - 1) ? MODS[i] - 1 : int'(lv);
                m_wrap[i] = 0;
            end else if (en) begin
                nxt       = m_q[i] + 1;
                m_wrap[i] = !SATS[i] && (nxt == MODS[i]);
                if (nxt >= MODS[i]) m_ovf[i] = 1;
                m_q[i]    = SATS[i] ? ((nxt >= MODS[i]) ? MODS[i] - 1 : nxt) : (nxt % MODS[i]);
            end else begin
                m_wrap[i] = 0;
            end
            exp_q.push_back(W'(m_q[i]));
        end
    endtask

    task automatic check_state(input string ph);
        logic [W-1:0] e;
        for (int i = 0; i < N; i++) begin
            e = exp_q.pop_front();
            chk($sformatf("%s_q[%0d]", ph, i), dq[i], e);
            chk($sformatf("%s_wrap[%0d]", ph, i), dwrap[i], m_wrap[i]);
            chk($sformatf("%s_ovf[%0d]", ph, i), dovf[i], m_ovf[i]);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic e, input logic c, input logic l,
                        input logic [W-1:0] v, input string ph);
        en = e; clr = c; load = l; lv = v;
        #1;
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_tc[%0d]", ph, i), dtc[i], model_tc(i));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_state(ph);
    endtask

    task automatic check_all_zero(input string ph);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_q[%0d]", ph, i), dq[i], 0);
            chk($sformatf("%s_wrap[%0d]", ph, i), dwrap[i], 0);
            chk($sformatf("%s_ovf[%0d]", ph, i), dovf[i], 0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < N; i++) begin
            m_q[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
        end

        // Reset and free-run: covers wrap at 8, modulo 5 and saturate at once.
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 1'b0, 1'b0, '0, "run");
            chk("run_m8_q", dq[0], k % 8);
            chk("run_m8_wrap", dwrap[0], k == 8);
            chk("run_m8_ovf", dovf[0], k >= 8);
            chk("run_m5_q", dq[1], k % 5);
            chk("run_m5_wrap", dwrap[1], (k == 5) || (k == 10));
            chk("run_sat_q", dq[2], (k > 7) ? 7 : k);
            chk("run_sat_wrap", dwrap[2], 0);
            chk("run_sat_ovf", dovf[2], k >= 8);
        end
        en = 1'b1; #1;
        chk("run_sat_tc_held", dtc[2], 1);

        // Load and clamp, then wrap straight out of a clamped value.
        step(1'b0, 1'b0, 1'b1, 3'd3, "load3");
        chk("load3_m8_q", dq[0], 3);
        step(1'b0, 1'b0, 1'b1, 3'd7, "load7");
        chk("load7_m5_clamp", dq[1], 4);
        chk("load7_m8_q", dq[0], 7);
        step(1'b1, 1'b0, 1'b0, '0, "after_clamp");
        chk("after_clamp_m5_q", dq[1], 0);
        chk("after_clamp_m5_wrap", dwrap[1], 1);
        chk("after_clamp_sat_q", dq[2], 7);

        // Priority: clear beats load and enable; load beats enable at max.
        step(1'b0, 1'b0, 1'b1, 3'd6, "load6");
        step(1'b1, 1'b1, 1'b1, 3'd2, "clr_all");
        chk("clr_all_m8_q", dq[0], 0);
        chk("clr_all_m8_ovf", dovf[0], 0);
        step(1'b0, 1'b0, 1'b1, 3'd7, "load_max");
        en = 1'b1; load = 1'b1; lv = 3'd2; #1;
        chk("load_en_tc", dtc[0], 0);
        step(1'b1, 1'b0, 1'b1, 3'd2, "load_en");
        chk("load_en_m8_q", dq[0], 2);
        chk("load_en_m8_wrap", dwrap[0], 0);
        chk("load_en_m8_ovf", dovf[0], 0);

        // Asynchronous reset in mid-cycle at q=5.
        step(1'b0, 1'b0, 1'b1, 3'd4, "load4");
        step(1'b1, 1'b0, 1'b0, '0, "to5");
        chk("to5_m8_q", dq[0], 5);
        #2 rst = 1'b0;
        #1 check_all_zero("async_rst");
        for (int i = 0; i < N; i++) begin
            m_q[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
        end
        @(negedge clk);
        repeat (2) step(1'b1, 1'b0, 1'b0, '0, "rst_held");
        check_all_zero("rst_held_zero");
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, '0, "resume");
        chk("resume_m8_q", dq[0], 1);

        // Randomised traffic against the model.
        for (int k = 0; k < 300; k++) begin
            step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 19) == 0),
                 logic'($urandom_range(0, 9) == 0), W'($urandom_range(0, 7)), "rand");
        end

        chk("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
